// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the stack CPU and the loader/debug port.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the loader always wins ties.
module ram_port_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_readWriteN,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_out,
  input  logic [DW-1:0] mem_data_in,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  logic [1:0]    r_state;
  logic          r_last_owner;
  logic          r_we;
  logic          r_cpu_gnt;
  logic          r_ldr_gnt;
  logic          r_cpu_rvalid;
  logic          r_ldr_rvalid;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_mem_rwn;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_dout;
  logic          r_busy;

  logic [1:0]    w_next_state;
  logic          w_next_last_owner;
  logic          w_next_we;
  logic          w_next_cpu_gnt;
  logic          w_next_ldr_gnt;
  logic          w_next_cpu_rvalid;
  logic          w_next_ldr_rvalid;
  logic [DW-1:0] w_next_cpu_rdata;
  logic [DW-1:0] w_next_ldr_rdata;
  logic          w_next_mem_rwn;
  logic [AW-1:0] w_next_mem_addr;
  logic [DW-1:0] w_next_mem_dout;
  logic          w_pick_ldr;

  // The most recent grantee is also the owner of the access in flight.
`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign w_pick_ldr = ldr_req && (!cpu_req || (r_last_owner == OWN_CPU));
`else
  assign w_pick_ldr = ldr_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_last_owner <= OWN_LDR;
      r_we         <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_ldr_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rdata  <= '0;
      r_mem_rwn    <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_dout   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_last_owner;
      r_we         <= w_next_we;
      r_cpu_gnt    <= w_next_cpu_gnt;
      r_ldr_gnt    <= w_next_ldr_gnt;
      r_cpu_rvalid <= w_next_cpu_rvalid;
      r_ldr_rvalid <= w_next_ldr_rvalid;
      r_cpu_rdata  <= w_next_cpu_rdata;
      r_ldr_rdata  <= w_next_ldr_rdata;
      r_mem_rwn    <= w_next_mem_rwn;
      r_mem_addr   <= w_next_mem_addr;
      r_mem_dout   <= w_next_mem_dout;
      r_busy       <= (w_next_state != S_IDLE);
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    w_next_state      = r_state;
    w_next_last_owner = r_last_owner;
    w_next_we         = r_we;
    w_next_cpu_gnt    = 1'b0;
    w_next_ldr_gnt    = 1'b0;
    w_next_cpu_rvalid = 1'b0;
    w_next_ldr_rvalid = 1'b0;
    w_next_cpu_rdata  = r_cpu_rdata;
    w_next_ldr_rdata  = r_ldr_rdata;
    w_next_mem_rwn    = 1'b1;
    w_next_mem_addr   = r_mem_addr;
    w_next_mem_dout   = r_mem_dout;
    case (r_state)
      S_IDLE: begin
        if (cpu_req || ldr_req) begin
          w_next_state = S_ACCESS;
          if (w_pick_ldr) begin
            w_next_last_owner = OWN_LDR;
            w_next_ldr_gnt    = 1'b1;
            w_next_we         = ldr_we;
            w_next_mem_rwn    = ~ldr_we;
            w_next_mem_addr   = ldr_addr;
            w_next_mem_dout   = ldr_wdata;
          end else begin
            w_next_last_owner = OWN_CPU;
            w_next_cpu_gnt    = 1'b1;
            w_next_we         = cpu_we;
            w_next_mem_rwn    = ~cpu_we;
            w_next_mem_addr   = cpu_addr;
            w_next_mem_dout   = cpu_wdata;
          end
        end
      end
      S_ACCESS: begin
        w_next_state = r_we ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        w_next_state = S_IDLE;
        if (r_last_owner == OWN_LDR) begin
          w_next_ldr_rvalid = 1'b1;
          w_next_ldr_rdata  = mem_data_in;
        end else begin
          w_next_cpu_rvalid = 1'b1;
          w_next_cpu_rdata  = mem_data_in;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign cpu_gnt        = r_cpu_gnt;
  assign ldr_gnt        = r_ldr_gnt;
  assign cpu_rvalid     = r_cpu_rvalid;
  assign ldr_rvalid     = r_ldr_rvalid;
  assign cpu_rdata      = r_cpu_rdata;
  assign ldr_rdata      = r_ldr_rdata;
  assign mem_readWriteN = r_mem_rwn;
  assign mem_address    = r_mem_addr;
  assign mem_data_out   = r_mem_dout;
  assign busy           = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow-memory scoreboard and an arbitration model.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       cpu_req, cpu_we, ldr_req, ldr_we;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [7:0] cpu_rdata, ldr_rdata;
  logic       mem_readWriteN, busy;
  logic [7:0] mem_address, mem_data_out, mem_data_in;

  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  int n_cmp = 0;
  int n_fail = 0;
  int wr_cycles = 0;
  int exp_writes = 0;
  bit m_last_ldr = 1'b1;
  logic [7:0] exp_cpu_rd, exp_ldr_rd;

  ram_port_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .resetN(resetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_readWriteN(mem_readWriteN), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM stand-in: read data appears one cycle after the access cycle.
  always @(posedge clk) begin
    if (mem_readWriteN === 1'b0) ram[mem_address] <= mem_data_out;
    mem_data_in <= ram[mem_address];
  end

  always @(negedge clk) if (mem_readWriteN === 1'b0) wr_cycles++;

  // Expected arbitration winner when both requesters are present.
  function automatic bit tie_winner_ldr(input bit last_ldr);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    return !last_ldr;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input bit is_ldr, input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (is_ldr) begin ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
    else begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
  endtask

  // One access from a single requester; reports what the DUT did, checks are left to the caller.
  task automatic access(input bit is_ldr, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output int lat_g, output int lat_v, output logic [7:0] rd,
                        output bit cmd_ok, output bit stray);
    lat_g = -1; lat_v = -1; rd = 8'h00; cmd_ok = 1'b0; stray = 1'b0;
    @(negedge clk);
    drive(is_ldr, 1'b1, we, a, d);
    for (int t = 1; t <= 20 && lat_g < 0; t++) begin
      @(posedge clk); #1;
      if (is_ldr ? cpu_gnt : ldr_gnt) stray = 1'b1;
      if (is_ldr ? ldr_gnt : cpu_gnt) begin
        lat_g  = t;
        cmd_ok = (mem_address === a) && (mem_readWriteN === !we) && (!we || mem_data_out === d);
        drive(is_ldr, 1'b0, we, a, d);
      end
    end
    drive(is_ldr, 1'b0, we, a, d);
    if (lat_g >= 0 && !we) begin
      for (int t = lat_g + 1; t <= lat_g + 10 && lat_v < 0; t++) begin
        @(posedge clk); #1;
        if (is_ldr ? cpu_rvalid : ldr_rvalid) stray = 1'b1;
        if (is_ldr ? ldr_rvalid : cpu_rvalid) begin
          lat_v = t;
          rd = is_ldr ? ldr_rdata : cpu_rdata;
        end
      end
    end else if (lat_g >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [37:0] got;
    resetN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    got = {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, busy, mem_readWriteN,
           mem_address, mem_data_out, cpu_rdata, ldr_rdata};
    n_cmp++;
    if (got !== {5'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", got, {5'b0, 1'b1, 32'h0});
    end
    @(negedge clk) resetN = 1'b1;
    m_last_ldr = 1'b1;
    exp_cpu_rd = 8'h00; exp_ldr_rd = 8'h00;
  endtask

  task automatic test_contention;
    string got_s, exp_s;
    int grants;
    bit both, w;
    got_s = ""; exp_s = ""; grants = 0; both = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = tie_winner_ldr(m_last_ldr);
      exp_s = {exp_s, w ? "L" : "C"};
      m_last_ldr = w;
      shadow[w ? 8'h41 : 8'h40] = w ? 8'hB1 : 8'hB0;
      exp_writes++;
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'hB0);
    drive(1'b1, 1'b1, 1'b1, 8'h41, 8'hB1);
    for (int t = 0; t < 40 && grants < 4; t++) begin
      @(posedge clk); #1;
      if (cpu_gnt && ldr_gnt) both = 1'b1;
      if (cpu_gnt) begin got_s = {got_s, "C"}; grants++; end
      else if (ldr_gnt) begin got_s = {got_s, "L"}; grants++; end
    end
    drive(1'b0, 1'b0, 1'b1, 8'h40, 8'hB0);
    drive(1'b1, 1'b0, 1'b1, 8'h41, 8'hB1);
    @(posedge clk); #1;
    n_cmp++;
    if (got_s != exp_s) begin n_fail++; $display("FAIL contention_order: got %s want %s", got_s, exp_s); end
    n_cmp++;
    if (both) begin n_fail++; $display("FAIL contention_dual_gnt: got 1 want 0"); end
  endtask

  task automatic test_cpu_read;
    int lg, lv; logic [7:0] rd; bit ok, st;
    ram[8'h10] = 8'hA5; shadow[8'h10] = 8'hA5;
    access(1'b0, 1'b0, 8'h10, 8'h00, lg, lv, rd, ok, st);
    m_last_ldr = 1'b0; exp_cpu_rd = 8'hA5;
    n_cmp++;
    if (lg !== 1 || !ok) begin n_fail++; $display("FAIL t1_grant: got lat=%0d cmd_ok=%0d want lat=1 cmd_ok=1", lg, ok); end
    n_cmp++;
    if (lv !== 3 || rd !== 8'hA5) begin n_fail++; $display("FAIL t1_rdata: got lat=%0d data=%h want lat=3 data=a5", lv, rd); end
  endtask

  task automatic test_write_then_read;
    int lg, lv, w0; logic [7:0] rd; bit ok, st;
    w0 = wr_cycles;
    access(1'b1, 1'b1, 8'h20, 8'h3C, lg, lv, rd, ok, st);
    shadow[8'h20] = 8'h3C; exp_writes++;
    n_cmp++;
    if (lg !== 1 || !ok || st) begin n_fail++; $display("FAIL t2_write_cmd: got lat=%0d ok=%0d stray=%0d want 1/1/0", lg, ok, st); end
    n_cmp++;
    if (wr_cycles - w0 !== 1) begin n_fail++; $display("FAIL t2_we_width: got %0d want 1", wr_cycles - w0); end
    access(1'b0, 1'b0, 8'h20, 8'h00, lg, lv, rd, ok, st);
    m_last_ldr = 1'b0; exp_cpu_rd = 8'h3C;
    n_cmp++;
    if (lv !== 3 || rd !== 8'h3C) begin n_fail++; $display("FAIL t2_readback: got lat=%0d data=%h want lat=3 data=3c", lv, rd); end
  endtask

  task automatic test_request_while_busy;
    int k_g, k_rv, k_lg; bit addr_ok;
    k_g = -1; k_rv = -1; k_lg = -1; addr_ok = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int t = 0; t < 20 && k_g < 0; t++) begin
      @(posedge clk); #1;
      if (cpu_gnt) k_g = t;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h55, 8'h77);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (cpu_rvalid && k_rv < 0) k_rv = k;
      if (ldr_gnt && k_lg < 0) begin
        k_lg = k;
        addr_ok = (mem_address === 8'h55) && (mem_readWriteN === 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h55, 8'h77);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 8'h55, 8'h77);
    shadow[8'h55] = 8'h77; exp_writes++; m_last_ldr = 1'b1; exp_cpu_rd = shadow[8'h10];
    n_cmp++;
    if (k_g < 0 || k_rv !== 2 || k_lg !== 3) begin
      n_fail++; $display("FAIL t5_timing: got gnt=%0d rvalid=+%0d ldr_gnt=+%0d want rvalid=+2 ldr_gnt=+3", k_g, k_rv, k_lg);
    end
    n_cmp++;
    if (!addr_ok || cpu_rdata !== exp_cpu_rd) begin
      n_fail++; $display("FAIL t5_cmd: got addr_ok=%0d rdata=%h want 1 %h", addr_ok, cpu_rdata, exp_cpu_rd);
    end
  endtask

  task automatic test_withdrawn;
    bit seen_g, seen_ldr, bad_gnt, bad_addr;
    seen_g = 1'b0; bad_gnt = 1'b0; bad_addr = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'h66, 8'h5A);
    for (int t = 0; t < 20 && !seen_g; t++) begin
      @(posedge clk); #1;
      if (ldr_gnt) seen_g = 1'b1;
    end
    drive(1'b1, 1'b0, 1'b1, 8'h66, 8'h5A);
    drive(1'b0, 1'b1, 1'b0, 8'h99, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h99, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (cpu_gnt) bad_gnt = 1'b1;
      if (mem_address === 8'h99) bad_addr = 1'b1;
    end
    seen_ldr = seen_g;
    shadow[8'h66] = 8'h5A; exp_writes++; m_last_ldr = 1'b1;
    n_cmp++;
    if (!seen_ldr || bad_gnt || bad_addr) begin
      n_fail++; $display("FAIL t6_withdrawn: got ldr_gnt=%0d cpu_gnt=%0d cpu_addr_seen=%0d want 1/0/0", seen_ldr, bad_gnt, bad_addr);
    end
  endtask

  task automatic test_reset_mid_read;
    bit seen_g, late_rv;
    logic [37:0] got;
    seen_g = 1'b0; late_rv = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int t = 0; t < 20 && !seen_g; t++) begin
      @(posedge clk); #1;
      if (cpu_gnt) seen_g = 1'b1;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    @(posedge clk); #1;
    resetN = 1'b0;
    @(posedge clk); #1;
    got = {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, busy, mem_readWriteN,
           mem_address, mem_data_out, cpu_rdata, ldr_rdata};
    @(negedge clk) resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (cpu_rvalid || ldr_rvalid || busy) late_rv = 1'b1;
    end
    m_last_ldr = 1'b1; exp_cpu_rd = 8'h00; exp_ldr_rd = 8'h00;
    n_cmp++;
    if (!seen_g || got !== {5'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL t4_reset_state: got gnt_seen=%0d outs=%h want 1 %h", seen_g, got, {5'b0, 1'b1, 32'h0});
    end
    n_cmp++;
    if (late_rv) begin n_fail++; $display("FAIL t4_no_rvalid: got 1 want 0"); end
  endtask

  task automatic test_random;
    int lg, lv; logic [7:0] rd, a, d; bit ok, st, is_ldr, we;
    for (int i = 0; i < 40; i++) begin
      is_ldr = 1'($urandom_range(1));
      we     = 1'($urandom_range(1));
      a      = 8'($urandom);
      d      = 8'($urandom);
      access(is_ldr, we, a, d, lg, lv, rd, ok, st);
      m_last_ldr = is_ldr;
      n_cmp++;
      if (lg !== 1 || !ok || st) begin
        n_fail++; $display("FAIL rnd_cmd[%0d]: got lat=%0d ok=%0d stray=%0d want 1/1/0", i, lg, ok, st);
      end
      if (we) begin
        shadow[a] = d; exp_writes++;
      end else begin
        if (is_ldr) exp_ldr_rd = shadow[a]; else exp_cpu_rd = shadow[a];
        n_cmp++;
        if (lv !== 3 || rd !== shadow[a]) begin
          n_fail++; $display("FAIL rnd_read[%0d]: got lat=%0d data=%h want lat=3 data=%h", i, lv, rd, shadow[a]);
        end
      end
      n_cmp++;
      if (cpu_rdata !== exp_cpu_rd || ldr_rdata !== exp_ldr_rd) begin
        n_fail++; $display("FAIL rnd_hold[%0d]: got %h/%h want %h/%h", i, cpu_rdata, ldr_rdata, exp_cpu_rd, exp_ldr_rd);
      end
    end
    n_cmp++;
    if (wr_cycles !== exp_writes) begin
      n_fail++; $display("FAIL write_cycles: got %0d want %0d", wr_cycles, exp_writes);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    test_reset;
    test_contention;
    test_cpu_read;
    test_write_then_read;
    test_request_while_busy;
    test_withdrawn;
    test_reset_mid_read;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
